mul_sequencer: RTL and testbench

MUL_SEQUENCER -- requirements
Module: mul_sequencer

---
 rtl/mul_sequencer_pkg.sv | 29 ++
 rtl/mul_shift_add_dp.sv | 63 ++++++
 rtl/mul_sequencer.sv | 143 ++++++++++++++
 tb/tb_mul_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// mul_sequencer_pkg
//   Shared CPU definitions for the iterative multiplier.
//   - mul_state_t : sequencer state encoding (IDLE, RUN, FIX, DONE)
//   - dp_cmd_t    : command issued by the sequencer to the shift-add datapath
//   - FUNCT3_MUL / FUNCT7_MULDIV : MUL function-select code used by decode
//   No ports; imported by the decode logic, mul_sequencer and
//   mul_shift_add_dp.
// ---------------------------------------------------------------------------
package mul_sequencer_pkg;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_FIX  = 2'd2,
        MUL_DONE = 2'd3
    } mul_state_t;

    typedef enum logic [1:0] {
        DP_HOLD   = 2'd0,
        DP_LOAD   = 2'd1,
        DP_STEP   = 2'd2,
        DP_NEGATE = 2'd3
    } dp_cmd_t;

    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

endpackage

// File: rtl/mul_shift_add_dp.sv
// ---------------------------------------------------------------------------
// mul_shift_add_dp
//   Radix-2 shift-add multiplier datapath. The accumulator is 2*WIDTH bits:
//   the upper half collects partial sums, the lower half starts out holding
//   the multiplier and is shifted out one bit per step.
// Ports
//   clk     : clock, state changes on the falling edge
//   rst     : asynchronous active-high reset, clears all registers
//   cmd     : HOLD / LOAD / STEP / NEGATE
//   load_a  : multiplicand magnitude captured on LOAD
//   load_b  : multiplier magnitude captured on LOAD
//   acc     : current accumulator contents (the product after WIDTH steps)
// ---------------------------------------------------------------------------
module mul_shift_add_dp
    import mul_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  dp_cmd_t              cmd,
    input  logic [WIDTH-1:0]     load_a,
    input  logic [WIDTH-1:0]     load_b,
    output logic [2*WIDTH-1:0]   acc
);

    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH:0]     upper_sum;
    logic [2*WIDTH-1:0] step_val;

    // One shift-add step: the adder keeps its carry so the shifted-in top
    // bit is exact, which is what lets full-range magnitudes never overflow.
    always_comb begin
        upper_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        if (acc_q[0]) begin
            step_val = {upper_sum, acc_q[WIDTH-1:1]};
        end else begin
            step_val = {1'b0, acc_q[2*WIDTH-1:1]};
        end
    end

    // Accumulator and multiplicand registers, driven by the sequencer command.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            mcand <= '0;
            acc_q <= '0;
        end else begin
            case (cmd)
                DP_LOAD: begin
                    mcand <= load_a;
                    acc_q <= {{WIDTH{1'b0}}, load_b};
                end
                DP_STEP:   acc_q <= step_val;
                DP_NEGATE: acc_q <= (~acc_q) + {{(2*WIDTH-1){1'b0}}, 1'b1};
                default:   acc_q <= acc_q;
            endcase
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/mul_sequencer.sv
// ---------------------------------------------------------------------------
// mul_sequencer
//   Multi-cycle MUL unit beside the EX stage. Accepts a request, runs WIDTH
//   shift-add steps on operand magnitudes, fixes the sign, then strobes done
//   and loads product. Operands of zero take a one-cycle shortcut.
// Ports
//   clk       : clock, all state changes on the falling edge
//   rst       : asynchronous active-high reset
//   start     : MUL request from EX, level-sampled
//   signed_op : 1 = two's-complement operands, 0 = unsigned
//   op_a      : multiplicand
//   op_b      : multiplier
//   flush     : cancels the in-flight MUL (branch/jump)
//   stall     : combinational freeze request for PC/IR/DOF/EX latches
//   busy      : high whenever the sequencer is not in IDLE
//   done      : one-cycle result-valid strobe
//   product   : 2*WIDTH result, held until the next completed operation
// ---------------------------------------------------------------------------
module mul_sequencer
    import mul_sequencer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_op,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    input  logic                 flush,
    output logic                 stall,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    mul_state_t         state;
    logic [CNT_W-1:0]   cnt;
    logic               neg;
    logic               accept;
    logic               zero_op;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   b_load;
    dp_cmd_t            dp_cmd;
    logic [2*WIDTH-1:0] acc;

    // Operand conditioning. The magnitude of the most negative value wraps to
    // itself, which is the correct unsigned magnitude. On the zero shortcut
    // the multiplier is loaded as zero so the accumulator reads back 0.
    always_comb begin
        accept  = (state == MUL_IDLE) & start & ~flush;
        zero_op = (op_a == '0) | (op_b == '0);
        a_mag   = (signed_op & op_a[WIDTH-1]) ? (~op_a + 1'b1) : op_a;
        b_mag   = (signed_op & op_b[WIDTH-1]) ? (~op_b + 1'b1) : op_b;
        b_load  = zero_op ? '0 : b_mag;
    end

    // Datapath command decode; flush suppresses any further datapath work.
    always_comb begin
        dp_cmd = DP_HOLD;
        if (accept) begin
            dp_cmd = DP_LOAD;
        end else if ((state == MUL_RUN) & ~flush) begin
            dp_cmd = DP_STEP;
        end else if ((state == MUL_FIX) & ~flush & neg) begin
            dp_cmd = DP_NEGATE;
        end
    end

    // Stall is gated by rst so the pipeline is released during reset even
    // while start is still asserted.
    assign stall = ~rst & (accept | (state == MUL_RUN) | (state == MUL_FIX));

    // Sequencer FSM with registered busy/done/product. A start seen outside
    // IDLE falls through untouched, so operands, sign and counter are safe.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state   <= MUL_IDLE;
            cnt     <= '0;
            neg     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                MUL_IDLE: begin
                    if (accept) begin
                        neg   <= signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= zero_op ? MUL_DONE : MUL_RUN;
                    end
                end
                MUL_RUN: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= MUL_IDLE;
                    end else begin
                        cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (cnt == CNT_W'(WIDTH - 1)) begin
                            state <= MUL_FIX;
                        end
                    end
                end
                MUL_FIX: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= MUL_IDLE;
                    end else begin
                        state <= MUL_DONE;
                    end
                end
                MUL_DONE: begin
                    busy  <= 1'b0;
                    state <= MUL_IDLE;
                    if (!flush) begin
                        done    <= 1'b1;
                        product <= acc;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= MUL_IDLE;
                end
            endcase
        end
    end

    mul_shift_add_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk    (clk),
        .rst    (rst),
        .cmd    (dp_cmd),
        .load_a (a_mag),
        .load_b (b_load),
        .acc    (acc)
    );

endmodule

// File: tb/tb_mul_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mul_sequencer
//   Self-checking bench for mul_sequencer (WIDTH=32). The DUT updates on the
//   falling edge; the bench drives and samples just after the rising edge.
//   Expected products come from plain 64-bit arithmetic on sign- or
//   zero-extended operands; expected timing comes from the stated latencies.
// ---------------------------------------------------------------------------
module tb_mul_sequencer;

    localparam int W = 32;

    logic           clk;
    logic           rst;
    logic           start;
    logic           signed_op;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic           flush;
    logic           stall;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int             testsRun;
    int             testsFailed;
    logic [2*W-1:0] lastProduct;

    mul_sequencer #(
        .WIDTH (W),
        .CNT_W (6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .signed_op (signed_op),
        .op_a      (op_a),
        .op_b      (op_b),
        .flush     (flush),
        .stall     (stall),
        .busy      (busy),
        .done      (done),
        .product   (product)
    );

    // Free-running clock; DUT state changes on its falling edges.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference product from plain wide arithmetic on extended operands.
    function automatic logic [63:0] refProduct(input logic [31:0] a, input logic [31:0] b,
                                               input logic s);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = s ? {{32{a[31]}}, a} : {32'b0, a};
        eb = s ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    // Advance one DUT cycle and land just after the next rising edge.
    task automatic nextCycle();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // One complete multiply: checks stall request, latency, stall length,
    // product, strobe width and that product held until completion.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic s, input string tag);
        logic [63:0] expProd;
        bit          zeroPath;
        bit          seen;
        int          latency;
        int          stallCount;
        expProd  = refProduct(a, b, s);
        zeroPath = (a == 0) || (b == 0);
        @(posedge clk);
        #1;
        op_a      = a;
        op_b      = b;
        signed_op = s;
        flush     = 1'b0;
        start     = 1'b1;
        #1;
        checkOutput({tag, " stall-on-request"}, 64'(stall), 64'd1);
        stallCount = int'(stall);
        nextCycle();
        start = 1'b0;
        checkOutput({tag, " busy-after-accept"}, 64'(busy), 64'd1);
        checkOutput({tag, " product-held"}, product, lastProduct);
        stallCount += int'(stall);
        seen    = 0;
        latency = 0;
        for (int c = 1; c <= W + 10 && !seen; c++) begin
            nextCycle();
            if (stall) stallCount++;
            if (done) begin
                seen    = 1;
                latency = c;
            end
        end
        checkOutput({tag, " latency"}, 64'(latency), zeroPath ? 64'd1 : 64'(W + 2));
        checkOutput({tag, " stall-cycles"}, 64'(stallCount), zeroPath ? 64'd1 : 64'(W + 2));
        checkOutput({tag, " product"}, product, expProd);
        lastProduct = expProd;
        nextCycle();
        checkOutput({tag, " done-one-cycle"}, 64'(done), 64'd0);
        checkOutput({tag, " idle-after"}, 64'(busy), 64'd0);
    endtask

    // Cancel an operation on the given RUN cycle with flush.
    task automatic flushTest(input int runCycle);
        int doneCount;
        @(posedge clk);
        #1;
        op_a      = 32'h0000_1357;
        op_b      = 32'h0002_4680;
        signed_op = 1'b0;
        start     = 1'b1;
        nextCycle();
        start = 1'b0;
        for (int i = 1; i < runCycle; i++) nextCycle();
        flush = 1'b1;
        #1;
        checkOutput("flush stall-in-run", 64'(stall), 64'd1);
        nextCycle();
        flush = 1'b0;
        checkOutput("flush busy", 64'(busy), 64'd0);
        checkOutput("flush stall", 64'(stall), 64'd0);
        doneCount = int'(done);
        for (int i = 0; i < W + 5; i++) begin
            nextCycle();
            doneCount += int'(done);
        end
        checkOutput("flush no-done", 64'(doneCount), 64'd0);
        checkOutput("flush product-kept", product, lastProduct);
    endtask

    // Assert reset on the given RUN cycle with start still high.
    task automatic resetTest(input int runCycle);
        int doneCount;
        @(posedge clk);
        #1;
        op_a      = 32'hDEAD_BEEF;
        op_b      = 32'h0000_0101;
        signed_op = 1'b1;
        start     = 1'b1;
        nextCycle();
        start = 1'b0;
        for (int i = 1; i < runCycle; i++) nextCycle();
        rst   = 1'b1;
        start = 1'b1;
        #1;
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset stall", 64'(stall), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset product", product, 64'd0);
        doneCount = 0;
        nextCycle();
        doneCount += int'(done);
        rst   = 1'b0;
        start = 1'b0;
        lastProduct = '0;
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            doneCount += int'(done);
        end
        checkOutput("reset no-done", 64'(doneCount), 64'd0);
    endtask

    // Start held high across a whole operation: one result, then a new
    // acceptance on the first IDLE cycle after DONE.
    task automatic heldStartTest(input logic [31:0] a, input logic [31:0] b);
        int nDone;
        int firstDone;
        int secondDone;
        logic busyAfter;
        busyAfter  = 1'b0;
        nDone      = 0;
        firstDone  = 0;
        secondDone = 0;
        @(posedge clk);
        #1;
        op_a      = a;
        op_b      = b;
        signed_op = 1'b0;
        start     = 1'b1;
        for (int e = 0; e <= 2 * W + 8; e++) begin
            nextCycle();
            if (done) begin
                nDone++;
                if (nDone == 1) firstDone = e;
                else if (nDone == 2) secondDone = e;
            end
            if (e == W + 3) begin
                busyAfter = busy;
                start     = 1'b0;
            end
        end
        checkOutput("held first-done", 64'(firstDone), 64'(W + 2));
        checkOutput("held reaccept", 64'(busyAfter), 64'd1);
        checkOutput("held second-done", 64'(secondDone), 64'(2 * W + 5));
        checkOutput("held done-count", 64'(nDone), 64'd2);
        lastProduct = refProduct(a, b, 1'b0);
        checkOutput("held product", product, lastProduct);
    endtask

    // Directed scenarios, boundary cases, then randomized operands.
    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        testsRun    = 0;
        testsFailed = 0;
        lastProduct = '0;
        rst       = 1'b1;
        start     = 1'b0;
        signed_op = 1'b0;
        op_a      = '0;
        op_b      = '0;
        flush     = 1'b0;
        #2;
        checkOutput("reset-state busy", 64'(busy), 64'd0);
        checkOutput("reset-state done", 64'(done), 64'd0);
        checkOutput("reset-state stall", 64'(stall), 64'd0);
        checkOutput("reset-state product", product, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        applyStimulus(32'h0000_0003, 32'h0000_0005, 1'b0, "u3x5");
        applyStimulus(32'hFFFF_FFFE, 32'h0000_0007, 1'b1, "s-2x7");
        applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b1, "sminxmin");
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "umaxxmax");
        applyStimulus(32'h0000_1234, 32'h0000_0000, 1'b0, "zero-b");
        applyStimulus(32'h0000_0000, 32'h8000_0001, 1'b1, "zero-a");
        applyStimulus(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, "smaxxmin");

        flushTest(10);

        // flush together with start in IDLE keeps the block idle
        @(posedge clk);
        #1;
        op_a  = 32'h0000_0011;
        op_b  = 32'h0000_0022;
        start = 1'b1;
        flush = 1'b1;
        #1;
        checkOutput("idle-flush stall", 64'(stall), 64'd0);
        nextCycle();
        start = 1'b0;
        flush = 1'b0;
        checkOutput("idle-flush busy", 64'(busy), 64'd0);
        nextCycle();
        checkOutput("idle-flush done", 64'(done), 64'd0);

        resetTest(20);
        applyStimulus(32'h0000_00FF, 32'hFFFF_FF00, 1'b1, "post-reset");

        heldStartTest(32'h0001_0003, 32'h0000_0009);

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: ra = 32'h8000_0000;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'h0;
                3: ra = 32'h1;
                default: ;
            endcase
            applyStimulus(ra, rb, rs, $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
